// File: rtl/midi_encoder_if.sv
// Message request/acknowledge bundle between a MIDI message producer and midi_encoder.
interface midi_encoder_if;
  logic       midi_send;
  logic [7:0] midi_byte0;
  logic [7:0] midi_byte1;
  logic [7:0] midi_byte2;
  logic       busy;
  logic       midi_byte_done;
  logic       midi_error;

  modport master (
    output midi_send, midi_byte0, midi_byte1, midi_byte2,
    input  busy, midi_byte_done, midi_error
  );

  modport slave (
    input  midi_send, midi_byte0, midi_byte1, midi_byte2,
    output busy, midi_byte_done, midi_error
  );
endinterface

// File: rtl/midi_encoder.sv
// MIDI OUT transmitter: sizes a status+data message, applies running status and
// shifts the bytes out as back-to-back 8N1 frames using an internal bit-rate counter.
module midi_encoder #(
  parameter int CLOCK_DIVIDE   = 384,
  parameter bit RUNNING_STATUS = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  midi_encoder_if.slave ctl,
  output logic          midi_port,
  output logic [3:0]    tx_byte_dbg
);
  localparam int BIT_CLKS = 4 * CLOCK_DIVIDE;
  localparam int CW       = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CW-1:0] BAUD_LAST = CW'(BIT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t        state_reg, state_next;
  logic [CW-1:0] baud_cnt_reg;
  logic [2:0]    bit_cnt_reg;
  logic [1:0]    byte_idx_reg;
  logic [1:0]    msg_len_reg;
  logic [7:0]    msg_reg [3];
  logic [7:0]    last_status_reg;
  logic          error_reg;

  logic [7:0] data_in     [2];
  logic [7:0] data_masked [2];
  logic       is_channel;
  logic       skip_status;
  logic [1:0] base_len;
  logic [1:0] msg_len;
  logic       can_accept;
  logic       start_ok;
  logic       reject;
  logic       bit_end;
  logic       in_frame;
  logic       last_byte;
  logic [7:0] cur_byte;

  assign data_in[0] = ctl.midi_byte1;
  assign data_in[1] = ctl.midi_byte2;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mask
      assign data_masked[gi] = data_in[gi] & 8'h7F;
    end
  endgenerate

  // Message length from the status byte, before running-status reduction.
  always_comb begin
    is_channel = 1'b0;
    base_len   = 2'd1;
    case (ctl.midi_byte0[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: begin
        is_channel = 1'b1;
        base_len   = 2'd3;
      end
      4'hC, 4'hD: begin
        is_channel = 1'b1;
        base_len   = 2'd2;
      end
      4'hF: begin
        case (ctl.midi_byte0[3:0])
          4'h2:       base_len = 2'd3;
          4'h1, 4'h3: base_len = 2'd2;
          default:    base_len = 2'd1;
        endcase
      end
      default: ;
    endcase
    skip_status = RUNNING_STATUS && is_channel && (ctl.midi_byte0 == last_status_reg);
    msg_len     = skip_status ? (base_len - 2'd1) : base_len;
  end

  assign in_frame   = (state_reg == S_START) || (state_reg == S_DATA) || (state_reg == S_STOP);
  assign can_accept = (state_reg == S_IDLE) || (state_reg == S_DONE);
  assign start_ok   = can_accept && ctl.midi_send && ctl.midi_byte0[7];
  assign reject     = can_accept && ctl.midi_send && !ctl.midi_byte0[7];
  assign bit_end    = (baud_cnt_reg == BAUD_LAST);
  assign last_byte  = (byte_idx_reg == (msg_len_reg - 2'd1));

  always_comb begin
    case (byte_idx_reg)
      2'd0:    cur_byte = msg_reg[0];
      2'd1:    cur_byte = msg_reg[1];
      default: cur_byte = msg_reg[2];
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE, S_DONE: state_next = start_ok ? S_START : S_IDLE;
      S_START:        if (bit_end) state_next = S_DATA;
      S_DATA:         if (bit_end && (bit_cnt_reg == 3'd7)) state_next = S_STOP;
      S_STOP:         if (bit_end) state_next = last_byte ? S_DONE : S_START;
      default:        state_next = S_IDLE;
    endcase
  end

  always_comb begin
    midi_port          = 1'b1;
    ctl.busy           = in_frame;
    ctl.midi_byte_done = (state_reg == S_DONE);
    ctl.midi_error     = error_reg;
    case (state_reg)
      S_START: midi_port = 1'b0;
      S_DATA:  midi_port = cur_byte[bit_cnt_reg];
      default: ;
    endcase
    tx_byte_dbg = in_frame ? cur_byte[7:4] : 4'h0;
  end

  // Counters restart on every accepted message and only advance inside a frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baud_cnt_reg    <= '0;
      bit_cnt_reg     <= '0;
      byte_idx_reg    <= '0;
      msg_len_reg     <= '0;
      last_status_reg <= '0;
      error_reg       <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        msg_reg[i] <= '0;
      end
    end else begin
      error_reg <= reject;
      if (start_ok) begin
        baud_cnt_reg <= '0;
        bit_cnt_reg  <= '0;
        byte_idx_reg <= '0;
        msg_len_reg  <= msg_len;
        if (skip_status) begin
          msg_reg[0] <= data_masked[0];
          msg_reg[1] <= data_masked[1];
          msg_reg[2] <= 8'h00;
        end else begin
          msg_reg[0] <= ctl.midi_byte0;
          msg_reg[1] <= data_masked[0];
          msg_reg[2] <= data_masked[1];
        end
        if (is_channel) begin
          last_status_reg <= ctl.midi_byte0;
        end else if (ctl.midi_byte0[7:3] == 5'b11110) begin
          last_status_reg <= 8'h00;
        end
      end else if (in_frame) begin
        baud_cnt_reg <= bit_end ? '0 : (baud_cnt_reg + 1'b1);
        if (bit_end && (state_reg == S_DATA)) begin
          bit_cnt_reg <= bit_cnt_reg + 3'd1;
        end
        if (bit_end && (state_reg == S_STOP)) begin
          byte_idx_reg <= byte_idx_reg + 2'd1;
        end
      end
    end
  end
endmodule
